// File: rtl/pdp8_pkg.sv
// Shared PDP-8 types, widths and operate-group encodings for the fetch/decode stage.
package pdp8_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 12;

    typedef struct packed {
        logic                  AND;
        logic                  TAD;
        logic                  ISZ;
        logic                  DCA;
        logic                  JMS;
        logic                  JMP;
        logic [ADDR_WIDTH-1:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic NOP;
        logic IAC;
        logic RAL;
        logic RTL;
        logic RAR;
        logic RTR;
        logic CML;
        logic CMA;
        logic CIA;
        logic CLL;
        logic CLA1;
        logic CLA_CLL;
        logic HLT;
        logic OSR;
        logic SKP;
        logic SNL;
        logic SZL;
        logic SZA;
        logic SNA;
        logic SMA;
        logic SPA;
        logic CLA2;
    } pdp_op7_opcode_s;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StIndRd,
        StIndData,
        StIssue,
        StWait1,
        StWait,
        StHalted
    } ifd_state_e;

    localparam logic [11:0] OP7_NOP     = 12'o7000;
    localparam logic [11:0] OP7_IAC     = 12'o7001;
    localparam logic [11:0] OP7_RAL     = 12'o7004;
    localparam logic [11:0] OP7_RTL     = 12'o7006;
    localparam logic [11:0] OP7_RAR     = 12'o7010;
    localparam logic [11:0] OP7_RTR     = 12'o7012;
    localparam logic [11:0] OP7_CML     = 12'o7020;
    localparam logic [11:0] OP7_CMA     = 12'o7040;
    localparam logic [11:0] OP7_CIA     = 12'o7041;
    localparam logic [11:0] OP7_CLL     = 12'o7100;
    localparam logic [11:0] OP7_CLA1    = 12'o7200;
    localparam logic [11:0] OP7_CLA_CLL = 12'o7300;
    localparam logic [11:0] OP7_HLT     = 12'o7402;
    localparam logic [11:0] OP7_OSR     = 12'o7404;
    localparam logic [11:0] OP7_SKP     = 12'o7410;
    localparam logic [11:0] OP7_SNL     = 12'o7420;
    localparam logic [11:0] OP7_SZL     = 12'o7430;
    localparam logic [11:0] OP7_SZA     = 12'o7440;
    localparam logic [11:0] OP7_SNA     = 12'o7450;
    localparam logic [11:0] OP7_SMA     = 12'o7500;
    localparam logic [11:0] OP7_SPA     = 12'o7510;
    localparam logic [11:0] OP7_CLA2    = 12'o7600;

    // Z selects the current page; otherwise the offset lands in page zero.
    function automatic logic [ADDR_WIDTH-1:0] calc_ea(input logic [DATA_WIDTH-1:0] word,
                                                       input logic [ADDR_WIDTH-1:0] pc);
        return word[7] ? {pc[11:7], word[6:0]} : {5'b0, word[6:0]};
    endfunction

    function automatic pdp_mem_opcode_s build_mem_op(input logic [2:0]            opc,
                                                     input logic [ADDR_WIDTH-1:0] addr);
        pdp_mem_opcode_s op;
        op = '0;
        op.mem_inst_addr = addr;
        case (opc)
            3'o0:    op.AND = 1'b1;
            3'o1:    op.TAD = 1'b1;
            3'o2:    op.ISZ = 1'b1;
            3'o3:    op.DCA = 1'b1;
            3'o4:    op.JMS = 1'b1;
            3'o5:    op.JMP = 1'b1;
            default: op = '0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pdp_op7_decode.sv
// Exact-match decoder for the supported group-7 operate words; anything else is illegal.
module pdp_op7_decode
    import pdp8_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] word_i,
    output pdp_op7_opcode_s       op7_o,
    output logic                  op7_legal_o
);

    always_comb begin
        op7_o       = '0;
        op7_legal_o = 1'b1;
        unique case (word_i)
            OP7_NOP:     op7_o.NOP     = 1'b1;
            OP7_IAC:     op7_o.IAC     = 1'b1;
            OP7_RAL:     op7_o.RAL     = 1'b1;
            OP7_RTL:     op7_o.RTL     = 1'b1;
            OP7_RAR:     op7_o.RAR     = 1'b1;
            OP7_RTR:     op7_o.RTR     = 1'b1;
            OP7_CML:     op7_o.CML     = 1'b1;
            OP7_CMA:     op7_o.CMA     = 1'b1;
            OP7_CIA:     op7_o.CIA     = 1'b1;
            OP7_CLL:     op7_o.CLL     = 1'b1;
            OP7_CLA1:    op7_o.CLA1    = 1'b1;
            OP7_CLA_CLL: op7_o.CLA_CLL = 1'b1;
            OP7_HLT:     op7_o.HLT     = 1'b1;
            OP7_OSR:     op7_o.OSR     = 1'b1;
            OP7_SKP:     op7_o.SKP     = 1'b1;
            OP7_SNL:     op7_o.SNL     = 1'b1;
            OP7_SZL:     op7_o.SZL     = 1'b1;
            OP7_SZA:     op7_o.SZA     = 1'b1;
            OP7_SNA:     op7_o.SNA     = 1'b1;
            OP7_SMA:     op7_o.SMA     = 1'b1;
            OP7_SPA:     op7_o.SPA     = 1'b1;
            OP7_CLA2:    op7_o.CLA2    = 1'b1;
            default:     op7_legal_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// PDP-8 fetch/decode stage: fetches, resolves one level of indirection, issues one-hot ops
// and waits on the execution unit's stall/PC_value handshake before the next fetch.
module instr_fetch_decode
    import pdp8_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o0200
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output pdp_mem_opcode_s       pdp_mem_opcode,
    output pdp_op7_opcode_s       pdp_op7_opcode,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    output logic                  ifu_rd_req,
    output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  halted,
    output logic                  illegal_instr
);

    ifd_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [2:0]            ind_opc_q, ind_opc_d;
    pdp_mem_opcode_s       mem_op_q, mem_op_d;
    pdp_op7_opcode_s       op7_q, op7_d;
    logic                  rd_req_q, rd_req_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  halted_q, halted_d;
    logic                  illegal_q, illegal_d;

    pdp_op7_opcode_s       dec_op7;
    logic                  dec_op7_legal;
    logic [2:0]            dec_opc;

    assign dec_opc = ifu_rd_data[11:9];

    pdp_op7_decode u_op7_decode (
        .word_i      (ifu_rd_data),
        .op7_o       (dec_op7),
        .op7_legal_o (dec_op7_legal)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        ind_opc_d  = ind_opc_q;
        mem_op_d   = '0;
        op7_d      = '0;
        rd_req_d   = 1'b0;
        rd_addr_d  = '0;
        halted_d   = halted_q;
        illegal_d  = illegal_q;

        // Request outputs are registered, so they are raised on entry to a read state.
        unique case (state_q)
            StIdle: begin
                state_d   = StFetch;
                rd_req_d  = 1'b1;
                rd_addr_d = fetch_pc_q;
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                if (dec_opc == 3'o7) begin
                    if (dec_op7_legal) begin
                        op7_d   = dec_op7;
                        state_d = StIssue;
                    end else begin
                        illegal_d = 1'b1;
                        halted_d  = 1'b1;
                        state_d   = StHalted;
                    end
                end else if (dec_opc == 3'o6) begin
                    illegal_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = StHalted;
                end else if (ifu_rd_data[8]) begin
                    ind_opc_d = dec_opc;
                    rd_req_d  = 1'b1;
                    rd_addr_d = calc_ea(ifu_rd_data, fetch_pc_q);
                    state_d   = StIndRd;
                end else begin
                    mem_op_d = build_mem_op(dec_opc, calc_ea(ifu_rd_data, fetch_pc_q));
                    state_d  = StIssue;
                end
            end
            StIndRd: state_d = StIndData;
            StIndData: begin
                // Auto-index locations get no write-back; the pointer is used as read.
                mem_op_d = build_mem_op(ind_opc_q, ifu_rd_data);
                state_d  = StIssue;
            end
            StIssue: begin
                if (op7_q.HLT) begin
                    halted_d = 1'b1;
                    state_d  = StHalted;
                end else begin
                    state_d = StWait1;
                end
            end
            StWait1: state_d = StWait;
            StWait: begin
                if (!stall) begin
                    fetch_pc_d = PC_value;
                    rd_req_d   = 1'b1;
                    rd_addr_d  = PC_value;
                    state_d    = StFetch;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= START_ADDR;
            ind_opc_q  <= '0;
            mem_op_q   <= '0;
            op7_q      <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ind_opc_q  <= ind_opc_d;
            mem_op_q   <= mem_op_d;
            op7_q      <= op7_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
        end
    end

    assign base_addr      = START_ADDR;
    assign pdp_mem_opcode = mem_op_q;
    assign pdp_op7_opcode = op7_q;
    assign ifu_rd_req     = rd_req_q;
    assign ifu_rd_addr    = rd_addr_q;
    assign fetch_pc       = fetch_pc_q;
    assign halted         = halted_q;
    assign illegal_instr  = illegal_q;

endmodule
